// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects plus stall/flush control for the 5-stage MIPS pipeline
//   Parameters: MC_LATENCY = E-stage cycles of a multi-cycle op (2..16), CNT_W = stall counter width
//   Inputs : D/E/M/W register numbers and write/load/branch/multi-cycle flags
//   Outputs: ForwardAE/BE (EX operand muxes), ForwardAD/BD (branch comparator),
//            StallF/D/E, FlushE/M, McDoneE, saturating StallCount
module hazard_unit #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             MultiCycleE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushE,
    output logic             FlushM,
    output logic             McDoneE,
    output logic [CNT_W-1:0] StallCount
);
    typedef enum logic {IDLE, BUSY} mcStateT;
    mcStateT          state;
    logic [3:0]       cnt;
    logic [CNT_W-1:0] stallCnt;
    logic             lwStall, brStall, mcStall, hazStall;
    always_comb begin
        lwStall   = MemtoRegE && (RtE == RsD || RtE == RtD);
        brStall   = BranchD && ((RegWriteE && (WriteRegE == RsD || WriteRegE == RtD)) ||
                                (MemtoRegM && (WriteRegM == RsD || WriteRegM == RtD)));
        mcStall   = !rst && (state == IDLE ? MultiCycleE : cnt != 4'd0);
        hazStall  = !rst && (lwStall || brStall);
        ForwardAE = rst ? 2'b00 :
                    (|RsE && RegWriteM && WriteRegM == RsE) ? 2'b10 :
                    (|RsE && RegWriteW && WriteRegW == RsE) ? 2'b01 : 2'b00;
        ForwardBE = rst ? 2'b00 :
                    (|RtE && RegWriteM && WriteRegM == RtE) ? 2'b10 :
                    (|RtE && RegWriteW && WriteRegW == RtE) ? 2'b01 : 2'b00;
        ForwardAD = !rst && |RsD && RegWriteM && WriteRegM == RsD;
        ForwardBD = !rst && |RtD && RegWriteM && WriteRegM == RtD;
        StallF    = hazStall || mcStall;
        StallD    = StallF;
        StallE    = mcStall;
        FlushM    = mcStall;
        // the ID/EX register is held during a multi-cycle op, so it must not also be cleared
        FlushE    = hazStall && !mcStall;
        McDoneE   = !rst && state == BUSY && cnt == 4'd0;
        StallCount = rst ? '0 : stallCnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            stallCnt <= '0;
        end else begin
            if (state == IDLE && MultiCycleE) begin
                state <= BUSY;
                cnt   <= 4'(MC_LATENCY - 2);
            end else if (state == BUSY) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else state <= IDLE;
            end
            if (StallF && !(&stallCnt)) stallCnt <= stallCnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It produces the forwarding selects consumed by the EX stage operand muxes and the decode-stage branch comparator. It also generates stall and flush controls for load-use hazards, branch-in-decode hazards and multi-cycle EX operations such as mult/div. Multi-cycle operations are sequenced by an internal FSM and down-counter. A saturating stall-cycle performance counter is included.

Parameters:
MC_LATENCY, 4, total EX-stage occupancy in cycles of a multi-cycle op; legal range is 2..16.
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
RsD  in  5  source register rs of the instruction in D
RtD  in  5  source register rt of the instruction in D
RsE  in  5  source register rs of the instruction in E
RtE  in  5  source register rt of the instruction in E
WriteRegE  in  5  destination register of the instruction in E
WriteRegM  in  5  destination register of the instruction in M
WriteRegW  in  5  destination register of the instruction in W
RegWriteE  in  1  instruction in E writes the register file
RegWriteM  in  1  instruction in M writes the register file
RegWriteW  in  1  instruction in W writes the register file
MemtoRegE  in  1  instruction in E is a load
MemtoRegM  in  1  instruction in M is a load
BranchD  in  1  instruction in D is a branch
MultiCycleE  in  1  instruction in E is a multi-cycle op
ForwardAE  out  2  SrcA select: 00=RD1_E, 01=ResultW, 10=ALUOutM
ForwardBE  out  2  SrcB/WriteData select, same encoding as ForwardAE
ForwardAD  out  1  forward ALUOutM to the D-stage rs comparator
ForwardBD  out  1  forward ALUOutM to the D-stage rt comparator
StallF  out  1  hold the PC
StallD  out  1  hold the IF/ID register
StallE  out  1  hold the ID/EX register
FlushE  out  1  clear the ID/EX register (inject bubble)
FlushM  out  1  clear the EX/MEM register (inject bubble)
McDoneE  out  1  final cycle of a multi-cycle op
StallCount  out  CNT_W  cycles in which StallF was asserted, saturating

Behaviour:
- Forwarding (combinational):
  - ForwardAE=10 if RsE!=0 && RegWriteM && WriteRegM==RsE.
  - Otherwise ForwardAE=01 if RsE!=0 && RegWriteW && WriteRegW==RsE.
  - Otherwise ForwardAE=00.
  - ForwardBE follows the same rules with RtE. M always has priority over W.
  - ForwardAD = RsD!=0 && RegWriteM && WriteRegM==RsD. ForwardBD is the same with RtD.
- Load-use stall: lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- Branch stall: brstall = BranchD && [ (RegWriteE && (WriteRegE==RsD || WriteRegE==RtD)) || (MemtoRegM && (WriteRegM==RsD || WriteRegM==RtD)) ].
- Multi-cycle FSM (registered state, registered 4-bit cnt):
  - IDLE, MultiCycleE=1: mcstall=1. Next state BUSY, cnt<=MC_LATENCY-2.
  - BUSY, cnt!=0: mcstall=1, cnt<=cnt-1. MultiCycleE is ignored.
  - BUSY, cnt==0: mcstall=0, McDoneE=1. Next state IDLE.
  - The op therefore occupies E for exactly MC_LATENCY cycles, of which MC_LATENCY-1 are stalled.
  - The release cycle has no stall, so the next instruction enters E on the following edge. A MultiCycleE seen then starts a fresh op.
- Output combination:
  - StallF = StallD = lwstall | brstall | mcstall.
  - StallE = mcstall. FlushM = mcstall.
  - FlushE = (lwstall | brstall) & ~mcstall. E is never flushed while held.
- StallCount increments on each clock edge where StallF=1. It holds at all-ones; there is no wrap.
- Reset: while rst=1, every output is forced to 0, including the forward selects. On the edge, state<=IDLE, cnt<=0, StallCount<=0.
- A reset mid-op abandons the op. The first cycle after rst falls is IDLE with no stall unless inputs demand one.

Test Plan:
- Forward priority: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10. Then clear RegWriteM -> ForwardAE=01. Then set RsE=0 -> ForwardAE=00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1, StallE=0. Next cycle with MemtoRegE=0 -> all stalls 0. StallCount=1.
- Branch stall: BranchD=1, RegWriteE=1, WriteRegE=3, RtD=3 -> StallF=1, FlushE=1. Case WriteRegM=3 with RegWriteM=1 and MemtoRegM=0 -> no stall, ForwardBD=1.
- Multi-cycle with MC_LATENCY=4: MultiCycleE held at 1 -> StallF/StallD/StallE/FlushM=1 for 3 cycles, then 4th cycle McDoneE=1 with stalls 0. A simultaneous lwstall during BUSY -> FlushE=0.
- Back-to-back multi-cycle ops: MultiCycleE=1 continuously -> stall pattern 1,1,1,0,1,1,1,0. StallCount=6 after 8 cycles.
- Reset mid-op: rst=1 in the 2nd BUSY cycle -> all outputs 0 during reset. After release with MultiCycleE=0 -> state IDLE, StallCount=0.
